// File: rtl/vx_tag_pool.sv
// Tag allocator: grants the lowest-index free tag each cycle and takes tags back by index.
// Occupancy is held as a free mask plus a registered count; flush and reset free every tag.
module vx_tag_pool #(
  parameter int NUM_TAGS = 8,
  parameter int TAGW     = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1,
  parameter int CNTW     = $clog2(NUM_TAGS + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                alloc_valid,
  output logic                alloc_ready,
  output logic [TAGW-1:0]     alloc_tag,
  input  logic                release_valid,
  input  logic [TAGW-1:0]     release_tag,
  input  logic                flush,
  output logic                release_err,
  output logic [NUM_TAGS-1:0] in_use,
  output logic [CNTW-1:0]     count,
  output logic                full,
  output logic                empty
);

  localparam logic [TAGW:0]   TAG_LIMIT  = (TAGW + 1)'(NUM_TAGS);
  localparam logic [CNTW-1:0] FULL_COUNT = CNTW'(NUM_TAGS);

  logic [NUM_TAGS-1:0] free_mask;
  logic [NUM_TAGS-1:0] free_mask_n;
  logic [NUM_TAGS-1:0] grant_onehot;
  logic [NUM_TAGS-1:0] release_onehot;
  logic [CNTW-1:0]     count_r;
  logic                release_err_r;
  logic                alloc_fire;
  logic                release_in_range;
  logic                release_ok;
  logic                release_bad;

  // Grant comes only from registered state, so a same-cycle release is never bypassed.
  always_comb begin
    // NOTE: default before the loop so every path assigns alloc_tag; without it a latch is inferred.
    alloc_tag = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (free_mask[i]) alloc_tag = TAGW'(i);
    end
  end

  assign grant_onehot = free_mask & (~free_mask + NUM_TAGS'(1));
  assign alloc_ready  = (|free_mask) && !flush;
  assign alloc_fire   = alloc_valid && alloc_ready;

  // Out-of-range tags decode to an empty mask and therefore never count as allocated.
  assign release_in_range = {1'b0, release_tag} < TAG_LIMIT;
  assign release_onehot   = release_in_range ? (NUM_TAGS'(1) << release_tag) : '0;
  assign release_ok       = release_valid && !flush && (|(release_onehot & ~free_mask));
  assign release_bad      = release_valid && !flush && !release_ok;

  // Grant and release bits are always distinct, so clear-then-set order is irrelevant.
  always_comb begin
    free_mask_n = free_mask;
    if (alloc_fire) free_mask_n = free_mask_n & ~grant_onehot;
    if (release_ok) free_mask_n = free_mask_n | release_onehot;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      free_mask     <= '1;
      count_r       <= '0;
      release_err_r <= 1'b0;
    end else if (flush) begin
      free_mask     <= '1;
      count_r       <= '0;
      release_err_r <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      free_mask     <= free_mask_n;
      count_r       <= count_r + CNTW'(alloc_fire) - CNTW'(release_ok);
      release_err_r <= release_bad;
    end
  end

  assign in_use      = ~free_mask;
  assign count       = count_r;
  assign full        = (count_r == FULL_COUNT);
  assign empty       = (count_r == '0);
  assign release_err = release_err_r;

`ifndef SYNTHESIS
  count_matches_mask: assert property (@(posedge clk) disable iff (reset)
    $countones(~free_mask) == int'(count_r))
    else $error("vx_tag_pool: count disagrees with occupancy mask");

`ifdef VX_TAG_POOL_STRICT_RELEASE
  legal_release: assert property (@(posedge clk) disable iff (reset) !release_bad)
    else $error("vx_tag_pool: release of a free or out-of-range tag");
`endif
`endif

endmodule

// File: tb/tb_vx_tag_pool.sv
// Directed bench for vx_tag_pool: a set-of-tags model checked every cycle, plus literal checks
// from the test plan; a second 6-tag instance covers out-of-range release and non-power-of-2 size.
module tb_vx_tag_pool;

  localparam int NT  = 8;
  localparam int NT6 = 6;

  logic       clk = 1'b0;
  logic       reset;
  logic       alloc_valid, release_valid, flush;
  logic [2:0] release_tag;
  logic       alloc_ready, release_err, full, empty;
  logic [2:0] alloc_tag;
  logic [7:0] in_use;
  logic [3:0] count;

  logic       a6_valid, r6_valid, flush6;
  logic [2:0] r6_tag;
  logic       a6_ready, err6, full6, empty6;
  logic [2:0] tag6;
  logic [5:0] in_use6;
  logic [2:0] count6;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vx_tag_pool #(.NUM_TAGS(NT)) dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .release_valid(release_valid), .release_tag(release_tag), .flush(flush),
    .release_err(release_err), .in_use(in_use), .count(count), .full(full), .empty(empty)
  );

  vx_tag_pool #(.NUM_TAGS(NT6)) dut6 (
    .clk(clk), .reset(reset),
    .alloc_valid(a6_valid), .alloc_ready(a6_ready), .alloc_tag(tag6),
    .release_valid(r6_valid), .release_tag(r6_tag), .flush(flush6),
    .release_err(err6), .in_use(in_use6), .count(count6), .full(full6), .empty(empty6)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a set of allocated tags; the grant is the smallest tag not in the set.
  bit         m_used [NT];
  bit         n_used [NT];
  bit         m_err, n_err;
  int         m_first, m_count;
  bit         m_ready, m_fire, m_legal;
  logic [7:0] m_in_use;

  always_comb begin
    m_first = -1;
    for (int i = NT - 1; i >= 0; i--) if (!m_used[i]) m_first = i;
    m_count = 0;
    for (int i = 0; i < NT; i++) begin
      m_count += int'(m_used[i]);
      m_in_use[i] = m_used[i];
    end
    m_ready = (m_first >= 0) && !flush;
    m_fire  = alloc_valid && m_ready;
    m_legal = release_valid && !flush && (int'(release_tag) < NT) && m_used[release_tag];
    n_used  = m_used;
    if (flush) begin
      for (int i = 0; i < NT; i++) n_used[i] = 1'b0;
    end else begin
      if (m_fire) n_used[m_first] = 1'b1;
      if (m_legal) n_used[release_tag] = 1'b0;
    end
    n_err = release_valid && !flush && !m_legal;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NT; i++) m_used[i] <= 1'b0;
      m_err <= 1'b0;
    end else begin
      m_used <= n_used;
      m_err  <= n_err;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("model_ready", alloc_ready, m_ready);
      if (m_ready) check("model_tag", alloc_tag, m_first);
      check("model_in_use", in_use, m_in_use);
      check("model_count", count, m_count);
      check("model_full", full, m_count == NT);
      check("model_empty", empty, m_count == 0);
      check("model_err", release_err, m_err);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    alloc_valid = 1'b0; release_valid = 1'b0; release_tag = '0; flush = 1'b0;
    a6_valid = 1'b0; r6_valid = 1'b0; r6_tag = '0; flush6 = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state, then fill the pool in order.
    alloc_valid = 1'b1;
    #3;
    check("rst_ready", alloc_ready, 1);
    check("rst_tag", alloc_tag, 0);
    check("rst_full", full, 0);
    check("rst_empty", empty, 1);
    check("rst_in_use", in_use, 0);
    for (int i = 0; i < NT; i++) begin
      if (i > 0) #3;
      check("fill_tag", alloc_tag, i);
      check("fill_ready", alloc_ready, 1);
      next_cycle();
    end
    alloc_valid = 1'b0;
    #3;
    check("fill_ready_off", alloc_ready, 0);
    check("fill_count", count, 8);
    check("fill_full", full, 1);

    // Release tag 3 from a full pool; it becomes grantable one cycle later.
    next_cycle();
    release_valid = 1'b1; release_tag = 3'd3;
    #3 check("rel3_no_bypass", alloc_ready, 0);
    next_cycle();
    release_valid = 1'b0;
    #3;
    check("rel3_ready", alloc_ready, 1);
    check("rel3_tag", alloc_tag, 3);
    check("rel3_count", count, 7);
    alloc_valid = 1'b1;
    next_cycle();
    alloc_valid = 1'b0;
    #3;
    check("rel3_recount", count, 8);
    check("rel3_in_use", in_use, 8'hff);

    // Full pool with same-cycle release of 5 and alloc request: no grant until next cycle.
    release_valid = 1'b1; release_tag = 3'd5; alloc_valid = 1'b1;
    #3 check("rel5_no_grant", alloc_ready, 0);
    next_cycle();
    release_valid = 1'b0;
    #3;
    check("rel5_ready", alloc_ready, 1);
    check("rel5_tag", alloc_tag, 5);
    check("rel5_count", count, 7);
    next_cycle();
    alloc_valid = 1'b0;
    #3 check("rel5_full", full, 1);

    // Tags 0-2 held; alloc 3 while releasing 1.
    flush = 1'b1;
    #3 check("flush_ready", alloc_ready, 0);
    next_cycle();
    flush = 1'b0; alloc_valid = 1'b1;
    repeat (3) next_cycle();
    release_valid = 1'b1; release_tag = 3'd1;
    #3 check("swap_tag", alloc_tag, 3);
    next_cycle();
    alloc_valid = 1'b0; release_valid = 1'b0;
    #3;
    check("swap_in_use", in_use, 8'b0000_1101);
    check("swap_count", count, 3);
    check("swap_next", alloc_tag, 1);

    // Release of a free tag: one-cycle error pulse, no state change.
    release_valid = 1'b1; release_tag = 3'd6;
    #3 check("err_before", release_err, 0);
    next_cycle();
    release_valid = 1'b0;
    #3;
    check("err_pulse", release_err, 1);
    check("err_in_use", in_use, 8'b0000_1101);
    check("err_count", count, 3);
    next_cycle();
    #3 check("err_clear", release_err, 0);

    // Five held, flush with alloc request; illegal release during flush raises no error.
    alloc_valid = 1'b1;
    next_cycle();
    next_cycle();
    flush = 1'b1; release_valid = 1'b1; release_tag = 3'd7;
    #3;
    check("flush5_count", count, 5);
    check("flush5_no_grant", alloc_ready, 0);
    next_cycle();
    flush = 1'b0; alloc_valid = 1'b0; release_valid = 1'b0;
    #3;
    check("flush5_count0", count, 0);
    check("flush5_empty", empty, 1);
    check("flush5_tag", alloc_tag, 0);
    check("flush5_err", release_err, 0);

    // Asynchronous reset in mid-cycle.
    alloc_valid = 1'b1;
    repeat (3) next_cycle();
    alloc_valid = 1'b0;
    #1 check("arst_before", count, 3);
    #1 reset = 1'b1;
    #1;
    check("arst_count", count, 0);
    check("arst_in_use", in_use, 0);
    check("arst_ready", alloc_ready, 1);
    check("arst_empty", empty, 1);
    check("arst_tag", alloc_tag, 0);
    next_cycle();
    reset = 1'b0;

    // Six-tag pool: fill, then release tags 6 and 7, both beyond the pool.
    a6_valid = 1'b1;
    for (int i = 0; i < NT6; i++) begin
      #3 check("p6_tag", tag6, i);
      next_cycle();
    end
    a6_valid = 1'b0;
    #3;
    check("p6_ready", a6_ready, 0);
    check("p6_full", full6, 1);
    check("p6_count", count6, 6);
    r6_valid = 1'b1; r6_tag = 3'd6;
    next_cycle();
    r6_tag = 3'd7;
    #3;
    check("p6_err6", err6, 1);
    check("p6_in_use", in_use6, 6'h3f);
    next_cycle();
    r6_valid = 1'b0;
    #3;
    check("p6_err7", err6, 1);
    check("p6_count_kept", count6, 6);
    next_cycle();
    #3 check("p6_err_clear", err6, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
